// File: rtl/rps_pkg.sv
// Shared types and helpers for the reset/preset sequencer.
`timescale 1ns/1ps
package rps_pkg;

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_HOLD   = 2'd1,
      S_RUN    = 2'd2,
      S_PRESET = 2'd3
   } rps_state_e;

   // One counter serves both the reset hold and the preset pulse, so it is
   // sized for whichever of the two is longer.
   function automatic int cnt_width(input int hold, input int pre);
      int m;
      m = (hold > pre) ? hold : pre;
      return $clog2(m + 1);
   endfunction

   // Legal parameter set: at least two synchronizer flops, non-zero hold
   // and non-zero preset length.
   function automatic bit params_legal(input int sync, input int hold, input int pre);
      return (sync >= 2) && (hold >= 1) && (pre >= 1);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert, sync-deassert reset release chain. rel goes high
// SYNC_STAGES clock edges after reset is removed.
`timescale 1ns/1ps
module reset_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   output logic rel
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Clear the chain immediately on reset; shift a 1 in on every edge after.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rel = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_preset_sequencer.sv
// Reset/preset sequencer for a bank of async reset/preset flops.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_RESET  | reset asserted or release still in the synchronizer
//  S_HOLD   | release seen, rst_out held for the remaining hold cycles
//  S_RUN    | downstream flops free running, d capture meaningful
//  S_PRESET | preset pulse in progress (may be extended once by pending)
`timescale 1ns/1ps
module reset_preset_sequencer
   import rps_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int RESET_HOLD    = 4,
   parameter int PRESET_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic preset_req,
   output logic rst_out,
   output logic preset_out,
   output logic run,
   output logic busy
);

   localparam int CW = cnt_width(RESET_HOLD, PRESET_CYCLES);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
   localparam logic [CW-1:0] PRE_LAST  = CW'(PRESET_CYCLES - 1);

   if (!params_legal(SYNC_STAGES, RESET_HOLD, PRESET_CYCLES)) begin : g_bad_params
      $error("reset_preset_sequencer: need SYNC_STAGES>=2, RESET_HOLD>=1, PRESET_CYCLES>=1");
   end

   rps_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          pending_q, pending_d;
   logic          rst_out_q, preset_out_q, run_q, busy_q;
   logic          rel;

   reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_reset_sync (
      .clk   (clk),
      .reset (reset),
      .rel   (rel)
   );

   assign cnt_inc = cnt_q + CW'(1);

   // State, counter, pending flag and registered output decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_RESET;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         rst_out_q    <= 1'b1;
         preset_out_q <= 1'b0;
         run_q        <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         rst_out_q    <= (state_d == S_RESET) || (state_d == S_HOLD);
         preset_out_q <= (state_d == S_PRESET);
         run_q        <= (state_d == S_RUN);
         busy_q       <= (state_d != S_RUN);
      end
   end

   // Next-state logic. The edge that first sees rel already counts as the
   // first hold cycle, so HOLD leaves when the counter reaches
   // RESET_HOLD-1 and a hold of 1 skips HOLD entirely. A request on the
   // final preset edge restarts the pulse just like a pending one.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      unique case (state_q)
         S_RESET: begin
            cnt_d     = '0;
            pending_d = 1'b0;
            if (rel) begin
               if (RESET_HOLD == 1) state_d = S_RUN;
               else                 state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            pending_d = 1'b0;
            cnt_d     = cnt_inc;
            if (cnt_inc == HOLD_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            pending_d = 1'b0;
            if (preset_req) begin
               state_d = S_PRESET;
               cnt_d   = '0;
            end
         end
         S_PRESET: begin
            if (cnt_q == PRE_LAST) begin
               cnt_d = '0;
               if (pending_q || preset_req) begin
                  pending_d = 1'b0;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               cnt_d = cnt_inc;
               if (preset_req) pending_d = 1'b1;
            end
         end
         default: begin
            state_d = S_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   assign rst_out    = rst_out_q;
   assign preset_out = preset_out_q;
   assign run        = run_q;
   assign busy       = busy_q;

endmodule
